// File: rtl/univ_shift_reg_seq_if.sv
// Command/data bundle for univ_shift_reg_seq: valid/ready command port plus serial and status pins.
// Sized by WIDTH and SHAMT_W; these must match the attached shift register's parameters.
interface univ_shift_reg_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [SHAMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0]   data_in;
  logic               ser_in_l;
  logic               ser_in_r;
  logic [WIDTH-1:0]   data_out;
  logic               ser_out;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, data_in, ser_in_l, ser_in_r,
    input  cmd_ready, data_out, ser_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, data_in, ser_in_l, ser_in_r,
    output cmd_ready, data_out, ser_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_seq.sv
// Command-driven universal shift register; multi-bit shifts step one bit per clock. Optional SHIFT_ABORT_EN adds an abort input.
// Latency: LOAD/CLEAR/NOP done 1 cycle after accept, shift by N done N+1 cycles after accept.
// Backpressure: cmd_ready only in IDLE; commands offered while shifting are dropped, not queued.
module univ_shift_reg_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input logic                clk,
  input logic                reset_n,
  univ_shift_reg_seq_if.slave sr
`ifdef SHIFT_ABORT_EN
  ,
  input logic                abort
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic [0:0]         state;
  logic [SHAMT_W-1:0] count;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   q;
  logic               ser_q;
  logic               done_q;

  logic [WIDTH-1:0]   step_q;
  logic               step_ser;
  logic               accept;
  logic               abort_hit;

`ifdef SHIFT_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign accept       = sr.cmd_valid && (state == ST_IDLE);
  assign sr.cmd_ready = (state == ST_IDLE);
  assign sr.busy      = (state == ST_SHIFT);
  assign sr.done      = done_q;
  assign sr.data_out  = q;
  assign sr.ser_out   = ser_q;

  // One-bit step for the latched op; serial fill bits are taken live each step.
  always_comb begin
    step_q   = q;
    step_ser = ser_q;
    case (op_q)
      OP_SHL: begin
        step_q   = {q[WIDTH-2:0], sr.ser_in_l};
        step_ser = q[WIDTH-1];
      end
      OP_SHR: begin
        step_q   = {sr.ser_in_r, q[WIDTH-1:1]};
        step_ser = q[0];
      end
      OP_ROL: begin
        step_q   = {q[WIDTH-2:0], q[WIDTH-1]};
        step_ser = q[WIDTH-1];
      end
      OP_ROR: begin
        step_q   = {q[0], q[WIDTH-1:1]};
        step_ser = q[0];
      end
      OP_ASR: begin
        step_q   = {q[WIDTH-1], q[WIDTH-1:1]};
        step_ser = q[0];
      end
      default: begin
        step_q   = q;
        step_ser = ser_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      op_q   <= OP_NOP;
      q      <= '0;
      ser_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (sr.cmd_op)
              OP_LOAD: begin
                q      <= sr.data_in;
                done_q <= 1'b1;
              end
              OP_CLEAR: begin
                q      <= '0;
                done_q <= 1'b1;
              end
              OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: begin
                // A zero amount completes like a NOP without entering SHIFT.
                if (sr.cmd_amt != '0) begin
                  op_q  <= sr.cmd_op;
                  count <= sr.cmd_amt;
                  state <= ST_SHIFT;
                end else begin
                  done_q <= 1'b1;
                end
              end
              default: done_q <= 1'b1;
            endcase
          end
        end
        ST_SHIFT: begin
          if (abort_hit) begin
            state  <= ST_IDLE;
            count  <= '0;
            done_q <= 1'b1;
          end else begin
            q     <= step_q;
            ser_q <= step_ser;
            count <= count - 1'b1;
            if (count == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Scoreboarded random/directed bench for univ_shift_reg_seq (WIDTH=8, SHAMT_W=3); abort scenario when SHIFT_ABORT_EN is defined.
module tb_univ_shift_reg_seq;

  localparam int W  = 8;
  localparam int SA = 3;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLEAR = 3'd7;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    int           c;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];
  logic [W-1:0] mdl_q;
  logic         mdl_ser;

  univ_shift_reg_seq_if #(.WIDTH(W), .SHAMT_W(SA)) u_if ();

`ifdef SHIFT_ABORT_EN
  logic abort;
  univ_shift_reg_seq #(.WIDTH(W), .SHAMT_W(SA)) dut (
    .clk(clk), .reset_n(reset_n), .sr(u_if.slave), .abort(abort)
  );
`else
  univ_shift_reg_seq #(.WIDTH(W), .SHAMT_W(SA)) dut (
    .clk(clk), .reset_n(reset_n), .sr(u_if.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-operation reference: result of n one-bit steps, computed arithmetically.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] v, input int n,
                                input logic sl, input logic sr_bit, input logic sin,
                                output logic [W-1:0] r, output logic so);
    logic [63:0] x;
    logic [63:0] fill;
    int k;
    r  = v;
    so = sin;
    if (n == 0) return;
    fill = (64'd1 << n) - 64'd1;
    k = n % W;
    case (op)
      SHL: begin
        x  = ({56'd0, v} << n) | (sl ? fill : 64'd0);
        r  = x[W-1:0];
        so = x[W];
      end
      SHR, ASR: begin
        x  = {56'd0, v} | (((op == ASR) ? v[W-1] : sr_bit) ? (fill << W) : 64'd0);
        r  = W'(x >> n);
        so = x[n-1];
      end
      ROL: begin
        x  = {48'd0, v, v} << k;
        r  = x[2*W-1:W];
        so = v[(W - k) % W];
      end
      ROR: begin
        x  = {48'd0, v, v} >> k;
        r  = x[W-1:0];
        so = v[(n - 1) % W];
      end
      default: ;
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (u_if.busy && u_if.done) chk("busy_done_overlap", 64'd1, 64'd0);
      if (u_if.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_data", {56'd0, u_if.data_out}, {56'd0, e.d});
          chk("done_ser", {63'd0, u_if.ser_out}, {63'd0, e.s});
          chk("done_latency", 64'(cyc), 64'(e.c));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [SA-1:0] amt, input logic [W-1:0] din,
                       input logic sl, input logic srb);
    int guard;
    int n;
    logic [W-1:0] r, old_q, pr;
    logic so, old_ser, ps;
    guard = 0;
    while (!u_if.cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!u_if.cmd_ready) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = op;
    u_if.cmd_amt   = amt;
    u_if.data_in   = din;
    u_if.ser_in_l  = sl;
    u_if.ser_in_r  = srb;
    old_q   = mdl_q;
    old_ser = mdl_ser;
    n = 0;
    r = mdl_q;
    so = mdl_ser;
    case (op)
      LOAD:  r = din;
      CLEAR: r = '0;
      SHL, SHR, ROL, ROR, ASR: begin
        n = int'(amt);
        model(op, old_q, n, sl, srb, old_ser, r, so);
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    exp_q.push_back('{d: r, s: so, c: cyc + n});
    mdl_q   = r;
    mdl_ser = so;
    // While shifting, offer junk commands that must be ignored and check each step.
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      model(op, old_q, j - 1, sl, srb, old_ser, pr, ps);
      chk("step_data", {56'd0, u_if.data_out}, {56'd0, pr});
      chk("step_ser", {63'd0, u_if.ser_out}, {63'd0, ps});
      chk("step_busy", {63'd0, u_if.busy}, 64'd1);
      u_if.cmd_valid = 1'($urandom);
      u_if.cmd_op    = 3'($urandom);
      u_if.data_in   = W'($urandom);
    end
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    mdl_q   = '0;
    mdl_ser = 1'b0;
    reset_n = 1'b0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_op    = NOP;
    u_if.cmd_amt   = '0;
    u_if.data_in   = '0;
    u_if.ser_in_l  = 1'b0;
    u_if.ser_in_r  = 1'b0;
`ifdef SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_data", {56'd0, u_if.data_out}, 64'd0);
    chk("rst_ser", {63'd0, u_if.ser_out}, 64'd0);
    chk("rst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("rst_done", {63'd0, u_if.done}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready", {63'd0, u_if.cmd_ready}, 64'd1);
    @(negedge clk);

    issue(LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
    issue(CLEAR, 3'd0, 8'h00, 1'b0, 1'b0);
    issue(LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
    issue(ROL, 3'd3, 8'h00, 1'b0, 1'b0);
    issue(LOAD, 3'd0, 8'h96, 1'b0, 1'b0);
    issue(ASR, 3'd2, 8'h00, 1'b0, 1'b0);
    issue(LOAD, 3'd0, 8'h00, 1'b0, 1'b0);
    issue(SHR, 3'd4, 8'h00, 1'b0, 1'b1);
    issue(SHL, 3'd0, 8'h00, 1'b1, 1'b1);
    issue(NOP, 3'd5, 8'h3C, 1'b1, 1'b0);

`ifdef SHIFT_ABORT_EN
    begin
      int c0;
      issue(LOAD, 3'd0, 8'h01, 1'b0, 1'b0);
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = SHL;
      u_if.cmd_amt   = 3'd7;
      u_if.ser_in_l  = 1'b0;
      @(posedge clk);
      #1;
      c0 = cyc;
      exp_q.push_back('{d: 8'h04, s: 1'b0, c: c0 + 3});
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", {63'd0, u_if.cmd_ready}, 64'd1);
      mdl_q   = 8'h04;
      mdl_ser = 1'b0;
    end
`endif

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom), SA'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Asynchronous reset in the middle of a ROL by 5: no done may follow.
    issue(LOAD, 3'd0, 8'hA5, 1'b0, 1'b0);
    u_if.cmd_valid = 1'b1;
    u_if.cmd_op    = ROL;
    u_if.cmd_amt   = 3'd5;
    @(posedge clk);
    #1;
    @(negedge clk);
    u_if.cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_data", {56'd0, u_if.data_out}, 64'd0);
    chk("midrst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("midrst_done", {63'd0, u_if.done}, 64'd0);
    mdl_q   = '0;
    mdl_ser = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(LOAD, 3'd0, 8'h5A, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
